// File: rtl/ksa_swap_controller_if.sv
// Bundles the start/done handshake and the single-port S RAM bus of the
// RC4 key-scheduling controller.
interface ksa_swap_controller_if #(
    parameter int unsigned RAM_WIDTH  = 8,
    parameter int unsigned KEY_LENGTH = 3
);
    logic                    start;
    logic [8*KEY_LENGTH-1:0] key;
    logic                    busy;
    logic                    done;
    logic [RAM_WIDTH-1:0]    ram_q;
    logic [RAM_WIDTH-1:0]    address;
    logic [RAM_WIDTH-1:0]    ram_in;
    logic                    write_enable;

    // Controller side: owns the RAM bus and reports status.
    modport master (
        input  start, key, ram_q,
        output busy, done, address, ram_in, write_enable
    );

    // Sequencer / RAM side.
    modport slave (
        output start, key, ram_q,
        input  busy, done, address, ram_in, write_enable
    );
endinterface

// File: rtl/ksa_swap_controller.sv
// RC4 key-scheduling sequencer: walks i = 0..255 over a pre-seeded S RAM,
// accumulates j and swaps S[i] and S[j], six cycles per iteration.
module ksa_swap_controller #(
    parameter int unsigned RAM_WIDTH  = 8,
    parameter int unsigned KEY_LENGTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    ksa_swap_controller_if.master bus
);

    localparam int unsigned KW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StRdI,
        StCapI,
        StRdJ,
        StCapJ,
        StWrI,
        StWrJ,
        StDone
    } state_t;

    state_t                  state;
    logic [RAM_WIDTH-1:0]    i;
    logic [RAM_WIDTH-1:0]    j;
    logic [RAM_WIDTH-1:0]    si;
    logic [KW-1:0]           k;
    logic [8*KEY_LENGTH-1:0] key_reg;
    logic [7:0]              key_byte;
    logic [RAM_WIDTH-1:0]    j_next;

    // Select key byte k; byte 0 sits in the most significant position.
    always_comb begin
        key_byte = '0;
        for (int n = 0; n < KEY_LENGTH; n++) begin
            if (k == KW'(n)) begin
                key_byte = key_reg[8*(KEY_LENGTH-1-n) +: 8];
            end
        end
        j_next = j + bus.ram_q + RAM_WIDTH'(key_byte);
    end

    // Single FSM; every output is registered and loaded with the value the
    // next state presents, so nothing combinational reaches the RAM bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= StIdle;
            i                <= '0;
            j                <= '0;
            k                <= '0;
            si               <= '0;
            key_reg          <= '0;
            bus.address      <= '0;
            bus.ram_in       <= '0;
            bus.write_enable <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        key_reg     <= bus.key;
                        i           <= '0;
                        j           <= '0;
                        k           <= '0;
                        bus.address <= '0;
                        bus.busy    <= 1'b1;
                        state       <= StRdI;
                    end
                end
                StRdI: begin
                    state <= StCapI;
                end
                StCapI: begin
                    si          <= bus.ram_q;
                    j           <= j_next;
                    bus.address <= j_next;
                    state       <= StRdJ;
                end
                StRdJ: begin
                    state <= StCapJ;
                end
                StCapJ: begin
                    // ram_in itself holds S[j] for the S[i] write.
                    bus.address      <= i;
                    bus.ram_in       <= bus.ram_q;
                    bus.write_enable <= 1'b1;
                    state            <= StWrI;
                end
                StWrI: begin
                    bus.address <= j;
                    bus.ram_in  <= si;
                    state       <= StWrJ;
                end
                StWrJ: begin
                    bus.write_enable <= 1'b0;
                    bus.ram_in       <= '0;
                    if (i == {RAM_WIDTH{1'b1}}) begin
                        bus.address <= '0;
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                        state       <= StDone;
                    end else begin
                        i           <= i + 1'b1;
                        k           <= (k == KW'(KEY_LENGTH - 1)) ? '0 : k + 1'b1;
                        bus.address <= i + 1'b1;
                        state       <= StRdI;
                    end
                end
                StDone: begin
                    if (!bus.start) begin
                        bus.done <= 1'b0;
                        state    <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ksa_swap_controller.sv
// Scoreboard bench for ksa_swap_controller: a software KSA model queues the
// expected RAM writes, a negedge monitor checks every write the DUT issues.
module tb_ksa_swap_controller;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic seed = 1'b0;

    ksa_swap_controller_if #(.RAM_WIDTH(8), .KEY_LENGTH(3)) bus ();

    ksa_swap_controller #(.RAM_WIDTH(8), .KEY_LENGTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    wr_t        exp_q [$];
    int         model_s [256];
    int         passes = 0;
    int         total = 0;
    int         we_cnt = 0;
    int         wlog_n = 0;
    logic [7:0] wlog_a [8];
    logic [7:0] wlog_d [8];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Synchronous single-port S RAM, read data one cycle after the address.
    always @(posedge clk) begin
        if (seed) begin
            for (int n = 0; n < 256; n++) mem[n] <= 8'(n);
        end else if (bus.write_enable) begin
            mem[bus.address] <= bus.ram_in;
        end
        bus.ram_q <= mem[bus.address];
    end

    // Monitor: compare every write against the head of the expected queue.
    always @(negedge clk) begin
        if (bus.write_enable) begin
            we_cnt++;
            if (wlog_n < 8) begin
                wlog_a[wlog_n] = bus.address;
                wlog_d[wlog_n] = bus.ram_in;
                wlog_n++;
            end
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", int'(bus.address), int'(w.a));
                check("wr_data", int'(bus.ram_in), int'(w.d));
            end
        end
    end

    // Reference RC4 KSA on identity S: queues (i, S[j]) then (j, S[i]).
    task automatic build_model(input logic [23:0] kk);
        int s [256];
        int jj;
        int kb;
        int t;
        wr_t w;
        for (int n = 0; n < 256; n++) s[n] = n;
        jj = 0;
        exp_q.delete();
        for (int n = 0; n < 256; n++) begin
            kb = int'((kk >> (8 * (2 - (n % 3)))) & 24'hFF);
            jj = (jj + s[n] + kb) % 256;
            w.a = 8'(n);
            w.d = 8'(s[jj]);
            exp_q.push_back(w);
            w.a = 8'(jj);
            w.d = 8'(s[n]);
            exp_q.push_back(w);
            t = s[n];
            s[n] = s[jj];
            s[jj] = t;
        end
        for (int n = 0; n < 256; n++) model_s[n] = s[n];
    endtask

    task automatic seed_ram();
        @(posedge clk) #1 seed = 1'b1;
        @(posedge clk) #1 seed = 1'b0;
    endtask

    task automatic expect_log(input int idx, input int a, input int d);
        check($sformatf("log_addr%0d", idx), int'(wlog_a[idx]), a);
        check($sformatf("log_data%0d", idx), int'(wlog_d[idx]), d);
    endtask

    // Full run with start held; optionally changes key at edge chg_edge.
    task automatic run_ksa(input logic [23:0] kk, input int chg_edge);
        int edges;
        int busy_cnt;
        int bad;
        build_model(kk);
        seed_ram();
        we_cnt = 0;
        wlog_n = 0;
        edges = 0;
        busy_cnt = 0;
        @(posedge clk) #1;
        bus.key = kk;
        bus.start = 1'b1;
        while (edges < 2000) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) break;
            if (edges == chg_edge) bus.key = 24'hABCDEF;
        end
        check("done_edge", edges, 1537);
        check("busy_cycles", busy_cnt, 1536);
        check("we_count", we_cnt, 512);
        check("queue_drained", exp_q.size(), 0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("done_held", int'(bus.done), 1);
        end
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("done_fell", int'(bus.done), 0);
        check("idle_busy", int'(bus.busy), 0);
        bad = 0;
        for (int n = 0; n < 256; n++) if (int'(mem[n]) != model_s[n]) bad++;
        check("final_s_mismatches", bad, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.key = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_address", int'(bus.address), 0);
        check("rst_ram_in", int'(bus.ram_in), 0);
        check("rst_we", int'(bus.write_enable), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        #1 reset = 1'b0;

        run_ksa(24'h010203, 0);
        expect_log(0, 8'h00, 8'h01);
        expect_log(1, 8'h01, 8'h00);
        expect_log(2, 8'h01, 8'h03);
        expect_log(3, 8'h03, 8'h00);

        run_ksa(24'hFFFFFF, 0);
        expect_log(0, 8'h00, 8'hFF);
        expect_log(1, 8'hFF, 8'h00);
        expect_log(2, 8'h01, 8'h00);
        expect_log(3, 8'hFF, 8'h01);

        run_ksa(24'h000000, 0);
        expect_log(0, 8'h00, 8'h00);
        expect_log(1, 8'h00, 8'h00);
        expect_log(2, 8'h01, 8'h01);
        expect_log(3, 8'h01, 8'h01);
        expect_log(4, 8'h02, 8'h03);
        expect_log(5, 8'h03, 8'h02);

        // Abort a run with reset at edge 100, then rerun cleanly.
        build_model(24'h010203);
        seed_ram();
        @(posedge clk) #1;
        bus.key = 24'h010203;
        bus.start = 1'b1;
        repeat (100) @(posedge clk);
        #1 reset = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_we", int'(bus.write_enable), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_address", int'(bus.address), 0);
        reset = 1'b0;
        exp_q.delete();
        run_ksa(24'h010203, 0);

        // Key changes mid-run must be ignored.
        run_ksa(24'h010203, 10);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
